// File: rtl/instruction_sequencer.sv
// Program buffer, program counter and issue FSM that feed IR/wren to the ControlUnit.
// Each word is held on IR with wren=1 for HOLD cycles, then a one-cycle fetch gap.
module instruction_sequencer #(
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int HOLD  = 2
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          prog_we,
    input  logic [AW-1:0] prog_addr,
    input  logic [31:0]   prog_data,
    input  logic [AW:0]   prog_len,
    input  logic          start,
    input  logic          stop,
    output logic [31:0]   IR,
    output logic          wren,
    output logic [AW-1:0] pc,
    output logic          busy,
    output logic          done,
    output logic          illegal
);
    localparam int CW = (HOLD > 1) ? $clog2(HOLD) : 1;

    typedef enum logic [1:0] {IDLE, FETCH, ISSUE} state_t;

    state_t          state, state_nx;
    logic [31:0]     mem [DEPTH];
    logic [CW-1:0]   cnt, cnt_nx;
    logic [31:0]     ir_nx;
    logic [AW-1:0]   pc_nx;
    logic            wren_nx, busy_nx, done_nx, illegal_nx;
    logic [31:0]     word;
    logic [4:0]      opc;
    logic [AW:0]     len_c;
    logic            last;

    function automatic logic opc_legal(input logic [4:0] o);
        return ((o >= 5'd1) && (o <= 5'd13)) || (o == 5'd16);
    endfunction

    assign word  = mem[pc];
    assign opc   = word[31:27];
    assign len_c = (prog_len > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : prog_len;
    assign last  = ({1'b0, pc} == (len_c - (AW+1)'(1)));

    // Buffer is not reset; writes are locked out for the duration of a run.
    always_ff @(posedge clk) begin
        if (prog_we && !busy)
            mem[prog_addr] <= prog_data;
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state   <= IDLE;
            IR      <= '0;
            wren    <= 1'b0;
            pc      <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            illegal <= 1'b0;
            cnt     <= '0;
        end else begin
            state   <= state_nx;
            IR      <= ir_nx;
            wren    <= wren_nx;
            pc      <= pc_nx;
            busy    <= busy_nx;
            done    <= done_nx;
            illegal <= illegal_nx;
            cnt     <= cnt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:  if (start && !stop && (len_c != '0)) state_nx = FETCH;
            FETCH: if (stop || (opc == 5'd0) || !opc_legal(opc)) state_nx = IDLE;
                   else state_nx = ISSUE;
            ISSUE: if (stop) state_nx = IDLE;
                   else if (cnt == '0) state_nx = last ? IDLE : FETCH;
            default: state_nx = IDLE;
        endcase
    end

    // stop outranks every other transition in FETCH and ISSUE.
    always_comb begin
        ir_nx      = IR;
        wren_nx    = wren;
        pc_nx      = pc;
        busy_nx    = busy;
        done_nx    = done;
        illegal_nx = illegal;
        cnt_nx     = cnt;
        unique case (state)
            IDLE: begin
                if (start && !stop) begin
                    illegal_nx = 1'b0;
                    if (len_c == '0) begin
                        done_nx = 1'b1;
                    end else begin
                        pc_nx   = '0;
                        busy_nx = 1'b1;
                        done_nx = 1'b0;
                    end
                end
            end
            FETCH: begin
                if (stop) begin
                    wren_nx = 1'b0;
                    busy_nx = 1'b0;
                    done_nx = 1'b0;
                end else if (opc == 5'd0) begin
                    busy_nx = 1'b0;
                    done_nx = 1'b1;
                end else if (!opc_legal(opc)) begin
                    illegal_nx = 1'b1;
                    busy_nx    = 1'b0;
                    done_nx    = 1'b1;
                end else begin
                    ir_nx   = word;
                    wren_nx = 1'b1;
                    cnt_nx  = CW'(HOLD - 1);
                end
            end
            ISSUE: begin
                if (stop) begin
                    wren_nx = 1'b0;
                    busy_nx = 1'b0;
                    done_nx = 1'b0;
                end else if (cnt == '0) begin
                    wren_nx = 1'b0;
                    if (last) begin
                        busy_nx = 1'b0;
                        done_nx = 1'b1;
                    end else begin
                        pc_nx = pc + AW'(1);
                    end
                end else begin
                    cnt_nx = cnt - CW'(1);
                end
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_instruction_sequencer.sv
// Directed bench for instruction_sequencer with DEPTH=16, HOLD=2.
module tb_instruction_sequencer;
    localparam logic [31:0] W0 = 32'h8080008D;
    localparam logic [31:0] W1 = 32'h81000029;
    localparam logic [31:0] W2 = 32'h50090029;

    logic        clk = 1'b0;
    logic        clr = 1'b0;
    logic        prog_we = 1'b0;
    logic [3:0]  prog_addr = '0;
    logic [31:0] prog_data = '0;
    logic [4:0]  prog_len = '0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [31:0] ir;
    logic        wren, busy, done, illegal;
    logic [3:0]  pc;

    int n_checks = 0;
    int n_fail = 0;

    instruction_sequencer #(.DEPTH(16), .AW(4), .HOLD(2)) dut (
        .clk(clk), .clr(clr), .prog_we(prog_we), .prog_addr(prog_addr),
        .prog_data(prog_data), .prog_len(prog_len), .start(start), .stop(stop),
        .IR(ir), .wren(wren), .pc(pc), .busy(busy), .done(done), .illegal(illegal)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [3:0] a, input logic [31:0] d);
        prog_we = 1'b1; prog_addr = a; prog_data = d;
        tick();
        prog_we = 1'b0;
    endtask

    task automatic pulse_reset();
        clr = 1'b0;
        #2;
        clr = 1'b1;
    endtask

    task automatic start_run(input logic [4:0] len);
        prog_len = len;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        n_checks++; if (ir !== 32'h0) begin n_fail++; $display("FAIL reset_ir got %h exp 0", ir); end
        n_checks++; if (wren !== 1'b0) begin n_fail++; $display("FAIL reset_wren got %b exp 0", wren); end
        n_checks++; if (pc !== 4'd0) begin n_fail++; $display("FAIL reset_pc got %0d exp 0", pc); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b exp 0", done); end
        n_checks++; if (illegal !== 1'b0) begin n_fail++; $display("FAIL reset_illegal got %b exp 0", illegal); end
    endtask

    task automatic test_program();
        logic        exp_w  [9] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        logic [31:0] exp_ir [9] = '{W0, W0, W0, W1, W1, W1, W2, W2, W2};
        load(4'd0, W0);
        load(4'd1, W1);
        load(4'd2, W2);
        start_run(5'd3);
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL prog_busy_fetch got %b exp 1", busy); end
        n_checks++; if (wren !== 1'b0) begin n_fail++; $display("FAIL prog_wren_e0 got %b exp 0", wren); end
        for (int i = 0; i < 9; i++) begin
            tick();
            n_checks++; if (wren !== exp_w[i]) begin n_fail++; $display("FAIL prog_wren[%0d] got %b exp %b", i, wren, exp_w[i]); end
            n_checks++; if (ir !== exp_ir[i]) begin n_fail++; $display("FAIL prog_ir[%0d] got %h exp %h", i, ir, exp_ir[i]); end
        end
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL prog_done got %b exp 1", done); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL prog_busy got %b exp 0", busy); end
        n_checks++; if (pc !== 4'd2) begin n_fail++; $display("FAIL prog_pc got %0d exp 2", pc); end
        n_checks++; if (illegal !== 1'b0) begin n_fail++; $display("FAIL prog_illegal got %b exp 0", illegal); end
    endtask

    task automatic test_zero_opcode();
        load(4'd1, 32'h0);
        start_run(5'd3);
        for (int i = 0; i < 4; i++) tick();
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL zop_done got %b exp 1", done); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL zop_busy got %b exp 0", busy); end
        n_checks++; if (pc !== 4'd1) begin n_fail++; $display("FAIL zop_pc got %0d exp 1", pc); end
        n_checks++; if (illegal !== 1'b0) begin n_fail++; $display("FAIL zop_illegal got %b exp 0", illegal); end
        n_checks++; if (ir !== W0) begin n_fail++; $display("FAIL zop_ir got %h exp %h", ir, W0); end
        n_checks++; if (wren !== 1'b0) begin n_fail++; $display("FAIL zop_wren got %b exp 0", wren); end
    endtask

    task automatic test_illegal();
        pulse_reset();
        load(4'd0, 32'h70000000);
        start_run(5'd3);
        n_checks++; if (wren !== 1'b0) begin n_fail++; $display("FAIL ill_wren_e0 got %b exp 0", wren); end
        tick();
        n_checks++; if (illegal !== 1'b1) begin n_fail++; $display("FAIL ill_flag got %b exp 1", illegal); end
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL ill_done got %b exp 1", done); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ill_busy got %b exp 0", busy); end
        n_checks++; if (wren !== 1'b0) begin n_fail++; $display("FAIL ill_wren got %b exp 0", wren); end
        n_checks++; if (ir !== 32'h0) begin n_fail++; $display("FAIL ill_ir got %h exp 0", ir); end
        tick();
        n_checks++; if (wren !== 1'b0) begin n_fail++; $display("FAIL ill_wren_after got %b exp 0", wren); end
    endtask

    task automatic test_stop();
        load(4'd0, W0);
        load(4'd1, W1);
        start_run(5'd3);
        for (int i = 0; i < 4; i++) tick();
        n_checks++; if ((wren !== 1'b1) || (ir !== W1)) begin n_fail++; $display("FAIL stop_pre got wren=%b ir=%h exp wren=1 ir=%h", wren, ir, W1); end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        n_checks++; if (wren !== 1'b0) begin n_fail++; $display("FAIL stop_wren got %b exp 0", wren); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL stop_busy got %b exp 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL stop_done got %b exp 0", done); end
        n_checks++; if (pc !== 4'd1) begin n_fail++; $display("FAIL stop_pc got %0d exp 1", pc); end
        n_checks++; if (ir !== W1) begin n_fail++; $display("FAIL stop_ir got %h exp %h", ir, W1); end
        start_run(5'd3);
        n_checks++; if ((pc !== 4'd0) || (busy !== 1'b1)) begin n_fail++; $display("FAIL rerun_pc got pc=%0d busy=%b exp pc=0 busy=1", pc, busy); end
        tick();
        n_checks++; if ((wren !== 1'b1) || (ir !== W0)) begin n_fail++; $display("FAIL rerun_ir got wren=%b ir=%h exp wren=1 ir=%h", wren, ir, W0); end
        for (int i = 0; i < 8; i++) tick();
        n_checks++; if ((done !== 1'b1) || (pc !== 4'd2) || (ir !== W2)) begin n_fail++; $display("FAIL rerun_end got done=%b pc=%0d ir=%h exp done=1 pc=2 ir=%h", done, pc, ir, W2); end
    endtask

    task automatic test_async_reset();
        start_run(5'd3);
        for (int i = 0; i < 4; i++) tick();
        #2;
        clr = 1'b0;
        #1;
        n_checks++; if (ir !== 32'h0) begin n_fail++; $display("FAIL arst_ir got %h exp 0", ir); end
        n_checks++; if (wren !== 1'b0) begin n_fail++; $display("FAIL arst_wren got %b exp 0", wren); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL arst_busy got %b exp 0", busy); end
        n_checks++; if (pc !== 4'd0) begin n_fail++; $display("FAIL arst_pc got %0d exp 0", pc); end
        #3;
        clr = 1'b1;
        tick();
        n_checks++; if (wren !== 1'b0) begin n_fail++; $display("FAIL arst_release_wren got %b exp 0", wren); end
        start_run(5'd3);
        tick();
        n_checks++; if ((wren !== 1'b1) || (ir !== W0)) begin n_fail++; $display("FAIL arst_run_ir got wren=%b ir=%h exp wren=1 ir=%h", wren, ir, W0); end
        for (int i = 0; i < 8; i++) tick();
        n_checks++; if ((done !== 1'b1) || (pc !== 4'd2) || (ir !== W2)) begin n_fail++; $display("FAIL arst_run_end got done=%b pc=%0d ir=%h exp done=1 pc=2 ir=%h", done, pc, ir, W2); end
    endtask

    task automatic test_write_while_busy();
        start_run(5'd3);
        load(4'd0, 32'hDEADBEEF);
        for (int i = 0; i < 8; i++) tick();
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL wbusy_done got %b exp 1", done); end
        start_run(5'd3);
        tick();
        n_checks++; if (ir !== W0) begin n_fail++; $display("FAIL wbusy_mem got %h exp %h", ir, W0); end
        for (int i = 0; i < 8; i++) tick();
    endtask

    task automatic test_zero_len();
        pulse_reset();
        tick();
        start_run(5'd0);
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL zlen_done got %b exp 1", done); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL zlen_busy got %b exp 0", busy); end
        tick();
        n_checks++; if (wren !== 1'b0) begin n_fail++; $display("FAIL zlen_wren got %b exp 0", wren); end
    endtask

    task automatic test_start_stop_same();
        pulse_reset();
        tick();
        prog_len = 5'd3;
        start = 1'b1;
        stop = 1'b1;
        tick();
        start = 1'b0;
        stop = 1'b0;
        n_checks++; if ((busy !== 1'b0) || (done !== 1'b0)) begin n_fail++; $display("FAIL startstop got busy=%b done=%b exp busy=0 done=0", busy, done); end
        tick();
        n_checks++; if (wren !== 1'b0) begin n_fail++; $display("FAIL startstop_wren got %b exp 0", wren); end
    endtask

    initial begin
        #7;
        test_reset();
        clr = 1'b1;
        tick();
        test_program();
        test_zero_opcode();
        test_illegal();
        test_stop();
        test_async_reset();
        test_write_while_busy();
        test_zero_len();
        test_start_stop_same();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
